handshake_fifo: RTL and testbench

//   Circular-buffer FIFO joining a producer and a consumer, each through a

---
 rtl/handshake_fifo.sv | 142 ++++++++++++++
 tb/tb_handshake_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo.sv
// ============================================================================
// Module   : handshake_fifo
// Brief    : Circular-buffer FIFO with four-phase req/ack handshakes on the
//            producer (tx) and consumer (rx) sides; single clock domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_fifo #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_rdy,
  output logic             tx_done,
  input  logic [WIDTH-1:0] in_data,
  output logic             rx_rdy,
  input  logic             rx_done,
  output logic [WIDTH-1:0] out_data,
  output logic             empty,
  output logic             full
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_ACK  = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_VALID = 2'd1,
    RX_ACK   = 2'd2
  } rx_state_t;

  logic [WIDTH-1:0]   r_buf [DEPTH];
  logic [c_PTR_W-1:0] r_front;
  logic [c_PTR_W-1:0] r_back;
  logic [c_CNT_W-1:0] r_count;
  tx_state_t          r_tx_state;
  tx_state_t          w_tx_next;
  rx_state_t          r_rx_state;
  rx_state_t          w_rx_next;
  logic               w_incr;
  logic               w_decr;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_DEPTH_CNT);
  assign out_data = r_buf[r_front];
  assign tx_done  = (r_tx_state == TX_ACK);
  assign rx_rdy   = (r_rx_state == RX_VALID);

  // Producer side: one stored word per tx_rdy assertion.
  always_comb begin
    w_tx_next = r_tx_state;
    w_incr    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (tx_rdy && !full) begin
          w_incr    = 1'b1;
          w_tx_next = TX_ACK;
        end
      end
      TX_ACK: begin
        if (!tx_rdy) begin
          w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // Consumer side: present head word, pop on rx_done, wait for rx_done release.
  always_comb begin
    w_rx_next = r_rx_state;
    w_decr    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!empty && !rx_done) begin
          w_rx_next = RX_VALID;
        end
      end
      RX_VALID: begin
        if (rx_done) begin
          w_decr    = 1'b1;
          w_rx_next = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!rx_done) begin
          w_rx_next = RX_IDLE;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_rx_state <= RX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
      r_rx_state <= w_rx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front <= '0;
      r_back  <= '0;
      r_count <= '0;
    end else begin
      if (w_incr) begin
        r_back <= (r_back == c_LAST_PTR) ? '0 : r_back + c_PTR_W'(1);
      end
      if (w_decr) begin
        r_front <= (r_front == c_LAST_PTR) ? '0 : r_front + c_PTR_W'(1);
      end
      case ({w_incr, w_decr})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale contents are never observable as valid data.
  always_ff @(posedge clk) begin
    if (w_incr) begin
      r_buf[r_back] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_handshake_fifo.sv
// ============================================================================
// Module   : tb_handshake_fifo
// Brief    : Self-checking bench for handshake_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_handshake_fifo;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             tx_rdy;
  logic             tx_done;
  logic [WIDTH-1:0] in_data;
  logic             rx_rdy;
  logic             rx_done;
  logic [WIDTH-1:0] out_data;
  logic             empty;
  logic             full;

  int total = 0;
  int bad   = 0;

  // Reference: stored words in order plus handshake phase of each agent.
  logic [WIDTH-1:0] q[$];
  bit               m_tx_ack;
  int               m_rx;   // 0 waiting, 1 word offered, 2 waiting for rx_done release

  handshake_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_rdy   (tx_rdy),
    .tx_done  (tx_done),
    .in_data  (in_data),
    .rx_rdy   (rx_rdy),
    .rx_done  (rx_done),
    .out_data (out_data),
    .empty    (empty),
    .full     (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, need %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("tx_done", {31'd0, tx_done}, {31'd0, m_tx_ack});
    chk("rx_rdy", {31'd0, rx_rdy}, (m_rx == 1) ? 32'd1 : 32'd0);
    chk("empty", {31'd0, empty}, (q.size() == 0) ? 32'd1 : 32'd0);
    chk("full", {31'd0, full}, (q.size() == DEPTH) ? 32'd1 : 32'd0);
    chk("count", 32'(dut.r_count), 32'(q.size()));
    if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // One clock: apply inputs, advance the model by the handshake rules, compare.
  task automatic step(input logic t, input logic [WIDTH-1:0] d, input logic r);
    bit push;
    bit pop;
    int n0;
    tx_rdy  = t;
    in_data = d;
    rx_done = r;
    n0   = q.size();
    push = !m_tx_ack && t && (n0 < DEPTH);
    pop  = (m_rx == 1) && r;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    if (!m_tx_ack) m_tx_ack = push;
    else if (!t)   m_tx_ack = 1'b0;
    case (m_rx)
      0: if (n0 > 0 && !r) m_rx = 1;
      1: if (r) m_rx = 2;
      default: if (!r) m_rx = 0;
    endcase
    check_outputs();
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    int n = 0;
    step(1'b1, d, 1'b0);
    while (!tx_done && n < 20) begin
      step(1'b1, d, 1'b0);
      n++;
    end
    chk("push_ack", {31'd0, tx_done}, 32'd1);
    step(1'b0, '0, 1'b0);
  endtask

  task automatic pop_word(input logic [WIDTH-1:0] exp);
    int n = 0;
    while (!rx_rdy && n < 20) begin
      step(1'b0, '0, 1'b0);
      n++;
    end
    chk("pop_rdy", {31'd0, rx_rdy}, 32'd1);
    chk("pop_data", 32'(out_data), 32'(exp));
    n = 0;
    step(1'b0, '0, 1'b1);
    while (rx_rdy && n < 20) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    step(1'b0, '0, 1'b0);
  endtask

  // Asserts reset mid-cycle and checks the outputs react without a clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
    chk("rst_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", 32'(dut.r_count), 32'd0);
    q.delete();
    m_tx_ack = 1'b0;
    m_rx     = 0;
    tx_rdy   = 1'b0;
    rx_done  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    rst_n   = 1'b0;
    tx_rdy  = 1'b0;
    rx_done = 1'b0;
    in_data = '0;
    m_tx_ack = 1'b0;
    m_rx     = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Fill to DEPTH; write pointer wraps back to 0.
    for (int i = 0; i < DEPTH; i++) begin
      push_word(8'h10 + 8'(i));
      repeat (8) step(1'b0, '0, 1'b0);
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("back_wrap", 32'(dut.r_back), 32'd0);

    // Push attempt while full must stall without overwriting.
    repeat (20) step(1'b1, 8'hAA, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("no_overwrite", 32'(out_data), 32'h10);

    // Drain in push order; read pointer wraps back to 0.
    for (int i = 0; i < DEPTH; i++) pop_word(8'h10 + 8'(i));
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("front_wrap", 32'(dut.r_front), 32'd0);
    repeat (5) step(1'b0, '0, 1'b0);

    // Simultaneous push and pop with two words stored.
    push_word(8'hA1);
    push_word(8'hA2);
    chk("sim_pre_rdy", {31'd0, rx_rdy}, 32'd1);
    step(1'b1, 8'hA3, 1'b1);
    chk("sim_count", 32'(dut.r_count), 32'd2);
    step(1'b0, '0, 1'b0);
    pop_word(8'hA2);
    pop_word(8'hA3);

    // Reset while the producer handshake is in its acknowledge phase.
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    step(1'b1, 8'h34, 1'b0);
    chk("mid_ack", {31'd0, tx_done}, 32'd1);
    do_reset();
    push_word(8'h5A);
    pop_word(8'h5A);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
